call_ret_unit: RTL and testbench
================================

Name: call_ret_unit

Overview:
- Parametrised call/return sequencer for the CPU fetch path.
- Selects the next PC from three sources: sequential increment, CALL target, or a return address popped from an internal return-address stack.
- Beyond a plain call/return block, it adds:
  - a single-level interrupt entry to a fixed vector, with RETI;
  - sticky overflow/underflow fault flags;
  - an optional trap-to-halt state machine.

Parameters:
- PC_W, 19, program-counter width.
- CALL_ADDR_W, 11, width of the CALL immediate; must be <= PC_W.
- DEPTH, 16, return-stack entries; power of two, >= 2.
- IRQ_VECTOR, 19'h00100, PC loaded on interrupt entry.
- TRAP_ON_FAULT, 1, 1 = a stack fault moves the FSM to HALT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  4  current instruction opcode.
- pc_current  in  PC_W  PC of the current instruction.
- call_addr  in  CALL_ADDR_W  CALL target, zero-extended.
- call_en  in  1  qualifies CALL.
- ret_en  in  1  qualifies RET/RETI.
- irq_req  in  1  level interrupt request.
- program_end  in  1  freezes the PC.
- pc_next  out  PC_W  next PC.
- pc_src  out  1  1 when the PC is redirected (call/ret/irq).
- irq_ack  out  1  combinational; high in the cycle the interrupt is taken.
- in_isr  out  1  registered; interrupt service in progress.
- stack_top  out  PC_W  mem[sp-1]; 0 when empty.
- sp_out  out  $clog2(DEPTH+1)  occupancy.
- stack_empty  out  1  sp_out == 0.
- stack_full  out  1  sp_out == DEPTH.
- overflow_err  out  1  sticky.
- underflow_err  out  1  sticky.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (reset = 0, async):
  - sp = 0, state = RUN, in_isr = 0, overflow_err = 0, underflow_err = 0, halted = 0.
  - Stack contents are don't-care; stack_top reads 0 while empty.
- Opcodes (shared package): CALL = 4'b0111, RET = 4'b1000, RETI = 4'b1001.
- Combinational default: pc_next = pc_current + 1 (mod 2^PC_W), pc_src = 0, irq_ack = 0.
- Decision priority per cycle, highest first:
  1. halted
  2. program_end
  3. irq
  4. CALL
  5. RET/RETI
- HALT: pc_next = pc_current, pc_src = 0, no stack operation, irq ignored. Left only by reset.
- program_end = 1: pc_next = pc_current, no stack operation, state unchanged (not latched).
- IRQ take, when irq_req & !in_isr & !stack_full:
  - irq_ack = 1, pc_src = 1, pc_next = IRQ_VECTOR.
  - Push pc_current (the interrupted instruction re-executes on return).
  - in_isr <= 1 at the clock edge.
  - The concurrent opcode is discarded.
- IRQ pending while stack_full: not taken. Instruction proceeds normally; no error.
- CALL (opcode == CALL & call_en):
  - Not full: pc_src = 1, pc_next = zero-extended call_addr, push pc_current + 1.
  - Full: no push, pc_next = pc_current + 1, overflow_err <= 1. If TRAP_ON_FAULT, state <= HALT.
- RET / RETI (opcode & ret_en):
  - Not empty: pc_src = 1, pc_next = stack_top, pop.
  - RETI additionally clears in_isr. RETI while !in_isr acts as RET.
  - Empty: no pop, pc_next = pc_current + 1, underflow_err <= 1. If TRAP_ON_FAULT, state <= HALT.
- Nested CALL/RET inside an ISR uses the same LIFO stack, so RETI pops the interrupted PC.
- Stack timing:
  - Push/pop update mem and sp on the rising edge.
  - stack_top, empty and full reflect the new sp in the next cycle.
  - Push and pop are never both asserted in the same cycle.
- Error flags are sticky until reset. halted = (state == HALT).
- FSM: RUN -> HALT on a fault with TRAP_ON_FAULT = 1; HALT -> RUN only via reset. in_isr is an independent flag.
- Latency: pc_next is combinational (0-cycle); all state updates take 1 cycle.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_CALL, OP_RET, OP_RETI;
  - FSM enum state_t {RUN, HALT}.
- One sub-module, ras_stack:
  - parameters W, DEPTH;
  - ports push, pop, push_data, top, sp, empty, full;
  - async active-low reset of sp.
- Top level holds the priority/decision logic, the FSM, in_isr and the error flags.

Test Plan:
- CALL then RET: pc_current = 19'h00010, call_addr = 11'h040, CALL → pc_next = 19'h00040, sp 0→1, stack_top = 19'h00011. Next cycle, RET at 19'h00045 → pc_next = 19'h00011, sp 1→0.
- Overflow: 16 CALLs fill the stack (stack_full = 1). 17th CALL at 19'h00200 → pc_next = 19'h00201, pc_src = 0, overflow_err = 1. Next cycle halted = 1 and pc_next = pc_current.
- Underflow with TRAP_ON_FAULT = 0: RET on empty at 19'h00300 → pc_next = 19'h00301, underflow_err = 1, halted stays 0.
- IRQ over CALL: irq_req = 1 with a CALL at 19'h00020 → irq_ack = 1, pc_next = 19'h00100, stack_top = 19'h00020, in_isr = 1. Nested CALL/RET inside the ISR, then RETI → pc_next = 19'h00020, in_isr = 0.
- IRQ masked: a second irq_req while in_isr = 1 → no ack, plain increment.
- program_end = 1 with a CALL → pc_next = pc_current, sp unchanged.
- Async reset mid-ISR with sp = 3: assert reset low between clock edges → sp_out = 0, in_isr = 0, flags = 0, with no clock edge required.
- Wrap: pc_current = 19'h7FFFF, non-branch opcode → pc_next = 19'h00000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes and FSM encoding for
// the call/return fetch sequencer.
package cpu_pkg;
  localparam logic [3:0] OP_CALL = 4'b0111;
  localparam logic [3:0] OP_RET  = 4'b1000;
  localparam logic [3:0] OP_RETI = 4'b1001;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;
endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO; top is mem[sp-1],
// reading zero while the stack is empty.
module ras_stack #(
  parameter int W     = 19,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       empty,
  output logic                       full
);
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d, sp_m1;
  logic [AW-1:0]   wr_idx, top_idx;
  logic            do_push, do_pop;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_W'(DEPTH));
  assign sp      = sp_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign sp_m1   = sp_q - SP_W'(1);
  assign top_idx = sp_m1[AW-1:0];
  assign wr_idx  = sp_q[AW-1:0];
  assign top     = empty ? '0 : mem[top_idx];

  // Next occupancy from the guarded push/pop.
  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + SP_W'(1);
    else if (do_pop) sp_d = sp_m1;
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Storage needs no reset; empty masks it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end
endmodule

// File: rtl/call_ret_unit.sv
// Next-PC selection: increment, CALL,
// RET/RETI, single-level IRQ, fault trap.
module call_ret_unit
  import cpu_pkg::*;
#(
  parameter int                PC_W          = 19,
  parameter int                CALL_ADDR_W   = 11,
  parameter int                DEPTH         = 16,
  parameter logic [PC_W-1:0]   IRQ_VECTOR    = 19'h00100,
  parameter bit                TRAP_ON_FAULT = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 opcode,
  input  logic [PC_W-1:0]            pc_current,
  input  logic [CALL_ADDR_W-1:0]     call_addr,
  input  logic                       call_en,
  input  logic                       ret_en,
  input  logic                       irq_req,
  input  logic                       program_end,
  output logic [PC_W-1:0]            pc_next,
  output logic                       pc_src,
  output logic                       irq_ack,
  output logic                       in_isr,
  output logic [PC_W-1:0]            stack_top,
  output logic [$clog2(DEPTH+1)-1:0] sp_out,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic                       halted
);
  state_t          state_q, state_d;
  logic            in_isr_q, in_isr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push, pop;
  logic [PC_W-1:0] push_data, pc_inc;
  logic            is_call, is_ret, is_reti;
  logic            live, sel_hold;
  logic            sel_irq, sel_call, sel_ret;

  ras_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (stack_top),
    .sp        (sp_out),
    .empty     (stack_empty),
    .full      (stack_full)
  );

  assign pc_inc  = pc_current + PC_W'(1);
  assign is_call = call_en & (opcode == OP_CALL);
  assign is_reti = ret_en & (opcode == OP_RETI);
  assign is_ret  = is_reti |
                   (ret_en & (opcode == OP_RET));

  // One-hot priority selects so the decode
  // below can stay a unique case.
  assign sel_hold = halted | program_end;
  assign live     = ~sel_hold;
  assign sel_irq  = live & irq_req &
                    ~in_isr_q & ~stack_full;
  assign sel_call = live & ~sel_irq & is_call;
  assign sel_ret  = live & ~sel_irq &
                    ~is_call & is_ret;

  assign halted        = (state_q == HALT);
  assign in_isr        = in_isr_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

  // Next PC, stack op and next state.
  always_comb begin
    pc_next   = pc_inc;
    pc_src    = 1'b0;
    irq_ack   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    state_d   = state_q;
    in_isr_d  = in_isr_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    unique case (1'b1)
      sel_hold: pc_next = pc_current;
      sel_irq: begin
        irq_ack   = 1'b1;
        pc_src    = 1'b1;
        pc_next   = IRQ_VECTOR;
        push      = 1'b1;
        push_data = pc_current;
        in_isr_d  = 1'b1;
      end
      sel_call: begin
        if (!stack_full) begin
          pc_src  = 1'b1;
          pc_next = PC_W'(call_addr);
          push    = 1'b1;
        end else begin
          ovf_d = 1'b1;
          if (TRAP_ON_FAULT) state_d = HALT;
        end
      end
      sel_ret: begin
        if (!stack_empty) begin
          pc_src  = 1'b1;
          pc_next = stack_top;
          pop     = 1'b1;
          if (is_reti) in_isr_d = 1'b0;
        end else begin
          unf_d = 1'b1;
          if (TRAP_ON_FAULT) state_d = HALT;
        end
      end
      default: ;
    endcase
  end

  // FSM, ISR flag and sticky faults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      in_isr_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_isr_q <= in_isr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
endmodule

// File: tb/tb_call_ret_unit.sv
// Scoreboard bench for call_ret_unit with
// trap on and off.
module tb_call_ret_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [18:0] pc_current = '0;
  logic [10:0] call_addr = '0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic        irq_req = 1'b0;
  logic        program_end = 1'b0;

  logic [18:0] pc_next, stack_top;
  logic        pc_src, irq_ack, in_isr;
  logic [4:0]  sp_out;
  logic        stack_empty, stack_full;
  logic        overflow_err, underflow_err, halted;

  logic [18:0] n_pc_next, n_stack_top;
  logic        n_pc_src, n_irq_ack, n_in_isr;
  logic [4:0]  n_sp_out;
  logic        n_empty, n_full;
  logic        n_ovf, n_unf, n_halted;

  typedef struct {
    string       nm;
    logic [18:0] pc;
    logic        src;
    logic        ack;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  call_ret_unit dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .pc_current    (pc_current),
    .call_addr     (call_addr),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .irq_req       (irq_req),
    .program_end   (program_end),
    .pc_next       (pc_next),
    .pc_src        (pc_src),
    .irq_ack       (irq_ack),
    .in_isr        (in_isr),
    .stack_top     (stack_top),
    .sp_out        (sp_out),
    .stack_empty   (stack_empty),
    .stack_full    (stack_full),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .halted        (halted)
  );

  call_ret_unit #(.TRAP_ON_FAULT(1'b0)) dut_nt (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .pc_current    (pc_current),
    .call_addr     (call_addr),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .irq_req       (irq_req),
    .program_end   (program_end),
    .pc_next       (n_pc_next),
    .pc_src        (n_pc_src),
    .irq_ack       (n_irq_ack),
    .in_isr        (n_in_isr),
    .stack_top     (n_stack_top),
    .sp_out        (n_sp_out),
    .stack_empty   (n_empty),
    .stack_full    (n_full),
    .overflow_err  (n_ovf),
    .underflow_err (n_unf),
    .halted        (n_halted)
  );

  task automatic do_reset();
    reset = 1'b0;
    opcode = 4'h0;
    call_en = 1'b0;
    ret_en = 1'b0;
    irq_req = 1'b0;
    program_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction, queue its expected
  // result, compare at the falling edge, then
  // let the clock edge commit it.
  task automatic cycle(
    input string       nm,
    input logic [3:0]  op,
    input logic [18:0] pc,
    input logic [10:0] ca,
    input logic        ce,
    input logic        re,
    input logic        irq,
    input logic        pend,
    input logic [18:0] epc,
    input logic        esrc,
    input logic        eack
  );
    exp_t e;
    opcode = op;
    pc_current = pc;
    call_addr = ca;
    call_en = ce;
    ret_en = re;
    irq_req = irq;
    program_end = pend;
    e.nm = nm;
    e.pc = epc;
    e.src = esrc;
    e.ack = eack;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (pc_next !== e.pc) begin
      bad++;
      $display("FAIL %s pc_next got=%h exp=%h",
               e.nm, pc_next, e.pc);
    end
    total++;
    if (pc_src !== e.src) begin
      bad++;
      $display("FAIL %s pc_src got=%b exp=%b",
               e.nm, pc_src, e.src);
    end
    total++;
    if (irq_ack !== e.ack) begin
      bad++;
      $display("FAIL %s irq_ack got=%b exp=%b",
               e.nm, irq_ack, e.ack);
    end
    @(posedge clk);
    #1;
    opcode = 4'h0;
    call_en = 1'b0;
    ret_en = 1'b0;
    program_end = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({sp_out, stack_empty, stack_full} !== 7'b0000010) begin
      bad++;
      $display("FAIL reset_sp got=%0d/%b/%b exp=0/1/0",
               sp_out, stack_empty, stack_full);
    end
    total++;
    if (stack_top !== 19'h0) begin
      bad++;
      $display("FAIL reset_top got=%h exp=0", stack_top);
    end
    total++;
    if ({in_isr, overflow_err, underflow_err, halted} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {in_isr, overflow_err, underflow_err, halted});
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    cycle("call", OP_CALL, 19'h00010, 11'h040,
          1, 0, 0, 0, 19'h00040, 1, 0);
    total++;
    if (sp_out !== 5'd1 || stack_top !== 19'h00011) begin
      bad++;
      $display("FAIL call_push got=%0d/%h exp=1/00011",
               sp_out, stack_top);
    end
    cycle("ret", OP_RET, 19'h00045, 11'h0,
          0, 1, 0, 0, 19'h00011, 1, 0);
    total++;
    if (sp_out !== 5'd0 || stack_empty !== 1'b1) begin
      bad++;
      $display("FAIL ret_pop got=%0d/%b exp=0/1",
               sp_out, stack_empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle("wrap", 4'h3, 19'h7FFFF, 11'h0,
          0, 0, 0, 0, 19'h00000, 0, 0);
    cycle("callen_low", OP_CALL, 19'h00050, 11'h0AA,
          0, 0, 0, 0, 19'h00051, 0, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++)
      cycle("fill", OP_CALL, 19'(i * 16), 11'(i + 1),
            1, 0, 0, 0, 19'(i + 1), 1, 0);
    total++;
    if (stack_full !== 1'b1 || sp_out !== 5'd16 ||
        stack_top !== 19'h000F1) begin
      bad++;
      $display("FAIL fill got=%b/%0d/%h exp=1/16/000f1",
               stack_full, sp_out, stack_top);
    end
    cycle("ovf_call", OP_CALL, 19'h00200, 11'h123,
          1, 0, 1, 0, 19'h00201, 0, 0);
    total++;
    if (overflow_err !== 1'b1 || halted !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flags got=%b/%b exp=1/1",
               overflow_err, halted);
    end
    cycle("halt_hold", OP_CALL, 19'h00300, 11'h011,
          1, 0, 1, 0, 19'h00300, 0, 0);
    total++;
    if (sp_out !== 5'd16 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_stay got=%0d/%b exp=16/1",
               sp_out, halted);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle("unf_ret", OP_RET, 19'h00300, 11'h0,
          0, 1, 0, 0, 19'h00301, 0, 0);
    total++;
    if (n_unf !== 1'b1 || n_halted !== 1'b0 ||
        n_sp_out !== 5'd0) begin
      bad++;
      $display("FAIL unf_notrap got=%b/%b/%0d exp=1/0/0",
               n_unf, n_halted, n_sp_out);
    end
    total++;
    if (underflow_err !== 1'b1 || halted !== 1'b1) begin
      bad++;
      $display("FAIL unf_trap got=%b/%b exp=1/1",
               underflow_err, halted);
    end
  endtask

  task automatic test_irq();
    do_reset();
    cycle("irq_take", OP_CALL, 19'h00020, 11'h055,
          1, 0, 1, 0, 19'h00100, 1, 1);
    total++;
    if (in_isr !== 1'b1 || stack_top !== 19'h00020) begin
      bad++;
      $display("FAIL irq_state got=%b/%h exp=1/00020",
               in_isr, stack_top);
    end
    cycle("irq_masked", 4'h0, 19'h00100, 11'h0,
          0, 0, 1, 0, 19'h00101, 0, 0);
    cycle("isr_call", OP_CALL, 19'h00101, 11'h300,
          1, 0, 1, 0, 19'h00300, 1, 0);
    total++;
    if (sp_out !== 5'd2 || stack_top !== 19'h00102) begin
      bad++;
      $display("FAIL isr_nest got=%0d/%h exp=2/00102",
               sp_out, stack_top);
    end
    cycle("isr_ret", OP_RET, 19'h00301, 11'h0,
          0, 1, 0, 0, 19'h00102, 1, 0);
    cycle("reti", OP_RETI, 19'h00105, 11'h0,
          0, 1, 0, 0, 19'h00020, 1, 0);
    total++;
    if (in_isr !== 1'b0 || sp_out !== 5'd0) begin
      bad++;
      $display("FAIL reti_state got=%b/%0d exp=0/0",
               in_isr, sp_out);
    end
  endtask

  task automatic test_program_end();
    do_reset();
    cycle("pend_call", OP_CALL, 19'h00040, 11'h007,
          1, 0, 1, 1, 19'h00040, 0, 0);
    total++;
    if (sp_out !== 5'd0 || in_isr !== 1'b0) begin
      bad++;
      $display("FAIL pend_state got=%0d/%b exp=0/0",
               sp_out, in_isr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle("b2b_c1", OP_CALL, 19'h01000, 11'h010,
          1, 0, 0, 0, 19'h00010, 1, 0);
    cycle("b2b_c2", OP_CALL, 19'h00010, 11'h020,
          1, 0, 0, 0, 19'h00020, 1, 0);
    cycle("b2b_r1", OP_RET, 19'h00025, 11'h0,
          0, 1, 0, 0, 19'h00011, 1, 0);
    cycle("b2b_r2", OP_RETI, 19'h00013, 11'h0,
          0, 1, 0, 0, 19'h01001, 1, 0);
    total++;
    if (sp_out !== 5'd0 || underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%0d/%b exp=0/0",
               sp_out, underflow_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle("ar_irq", 4'h0, 19'h00050, 11'h0,
          0, 0, 1, 0, 19'h00100, 1, 1);
    cycle("ar_c1", OP_CALL, 19'h00100, 11'h010,
          1, 0, 0, 0, 19'h00010, 1, 0);
    cycle("ar_c2", OP_CALL, 19'h00010, 11'h020,
          1, 0, 0, 0, 19'h00020, 1, 0);
    irq_req = 1'b0;
    total++;
    if (sp_out !== 5'd3 || in_isr !== 1'b1) begin
      bad++;
      $display("FAIL ar_pre got=%0d/%b exp=3/1",
               sp_out, in_isr);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (sp_out !== 5'd0 || in_isr !== 1'b0 ||
        {overflow_err, underflow_err, halted} !== 3'b0) begin
      bad++;
      $display("FAIL ar_clear got=%0d/%b/%b exp=0/0/000",
               sp_out, in_isr,
               {overflow_err, underflow_err, halted});
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_wrap();
    test_overflow();
    test_underflow();
    test_irq();
    test_program_end();
    test_back_to_back();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
